// File: rtl/count_capture_pkg.sv
// count_capture_pkg
//   Shared definitions for the time-stamp capture block.
//   DROP_CNT_WIDTH : width of the saturating dropped-event counter
//   clog2()        : pointer sizing for the FIFO
//   ts_entry_t     : time-stamp entry {epoch, count} at the default 4+4 widths
package count_capture_pkg;

    localparam int DROP_CNT_WIDTH = 8;
    localparam int TS_EPOCH_W     = 4;
    localparam int TS_COUNT_W     = 4;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    typedef struct packed {
        logic [TS_EPOCH_W-1:0] epoch;
        logic [TS_COUNT_W-1:0] count;
    } ts_entry_t;

endpackage

// File: rtl/ts_fifo.sv
// ts_fifo
//   Synchronous FIFO with registered storage and combinational head read.
//   Pointers carry one extra wrap bit so full and empty can be told apart.
//   Ports:
//     clk, rst  : clock, synchronous active-high reset (flushes pointers)
//     push      : write wr_data; accepted when not full, or when full with a pop
//     pop       : remove head; ignored while empty
//     wr_data   : entry to write
//     rd_data   : current head (valid only while !empty)
//     full      : DEPTH entries held
//     empty     : no entries held
module ts_fifo
    import count_capture_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W:0]    wr_ptr;
    logic [PTR_W:0]    rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot the push lands in.
    assign do_push = push & (~full | do_pop);

    assign rd_data = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[PTR_W-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/count_timestamp_capture.sv
// count_timestamp_capture
//   Extends a free-running count with an epoch (overflow) counter and
//   time-stamps rising edges of event_in into a small FIFO drained by a
//   valid/ready consumer. Events arriving while the FIFO is full (and not
//   being popped) are dropped and counted in a saturating counter.
//   Optional macro CAPTURE_SYNC_EN: event_in passes through a 2-flop
//   synchroniser (reset to 1) before edge detection, adding 2 cycles.
//   Ports:
//     clk, rst     : clock, synchronous active-high reset
//     count_in     : counter value, same clock domain
//     overflow_in  : counter overflow flag; rising edge bumps the epoch
//     event_in     : event input; rising edge is captured
//     ts_data      : FIFO head {epoch, count}
//     ts_valid     : FIFO non-empty
//     ts_ready     : consumer pops head when ts_valid & ts_ready
//     fifo_full    : FIFO holds DEPTH entries
//     drop_cnt     : saturating count of events lost to a full FIFO
module count_timestamp_capture
    import count_capture_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int EPOCH_WIDTH = 4,
    parameter int DEPTH       = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH-1:0]             count_in,
    input  logic                         overflow_in,
    input  logic                         event_in,
    output logic [EPOCH_WIDTH+WIDTH-1:0] ts_data,
    output logic                         ts_valid,
    input  logic                         ts_ready,
    output logic                         fifo_full,
    output logic [DROP_CNT_WIDTH-1:0]    drop_cnt
);

    localparam logic [DROP_CNT_WIDTH-1:0] DROP_ONE = 1;

    logic                   ovf_d;
    logic                   evt_d;
    logic                   evt_s;
    logic                   ovf_rise;
    logic                   evt_rise;
    logic [EPOCH_WIDTH-1:0] epoch;
    logic [EPOCH_WIDTH-1:0] epoch_eff;
    logic                   fifo_empty;
    logic                   drop;

`ifdef CAPTURE_SYNC_EN
    logic sync1;
    logic sync2;

    // Reset high so an input already high at release does not look like an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= event_in;
            sync2 <= sync1;
        end
    end

    assign evt_s = sync2;
`else
    assign evt_s = event_in;
`endif

    assign ovf_rise  = overflow_in & ~ovf_d;
    assign evt_rise  = evt_s & ~evt_d;
    // An event in the overflow cycle must carry the new epoch, so the stamp
    // uses the incremented value rather than the registered one.
    assign epoch_eff = epoch + {{(EPOCH_WIDTH-1){1'b0}}, ovf_rise};

    assign ts_valid = ~fifo_empty;
    assign drop     = evt_rise & fifo_full & ~ts_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_d    <= 1'b0;
            evt_d    <= 1'b1;
            epoch    <= '0;
            drop_cnt <= '0;
        end else begin
            ovf_d <= overflow_in;
            evt_d <= evt_s;
            epoch <= epoch_eff;
            if (drop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + DROP_ONE;
            end
        end
    end

    ts_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (EPOCH_WIDTH + WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (evt_rise),
        .pop     (ts_ready),
        .wr_data ({epoch_eff, count_in}),
        .rd_data (ts_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_count_timestamp_capture.sv
module tb_count_timestamp_capture;
    import count_capture_pkg::*;

    logic       clk;
    logic       rst;
    logic [3:0] count_in;
    logic       overflow_in;
    logic       event_in;
    logic [7:0] ts_data;
    logic       ts_valid;
    logic       ts_ready;
    logic       fifo_full;
    logic [DROP_CNT_WIDTH-1:0] drop_cnt;

    int checks;
    int errors;

    count_timestamp_capture #(
        .WIDTH       (4),
        .EPOCH_WIDTH (4),
        .DEPTH       (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .count_in    (count_in),
        .overflow_in (overflow_in),
        .event_in    (event_in),
        .ts_data     (ts_data),
        .ts_valid    (ts_valid),
        .ts_ready    (ts_ready),
        .fifo_full   (fifo_full),
        .drop_cnt    (drop_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] stamp(input logic [3:0] e, input logic [3:0] c);
        ts_entry_t t;
        t.epoch = e;
        t.count = c;
        return t;
    endfunction

    // One rising edge of event_in at the given count, then event_in low again.
    task automatic pulse_event(input logic [3:0] c);
        count_in = c;
        event_in = 1'b1;
        step();
        event_in = 1'b0;
        step();
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        count_in    = 4'h0;
        overflow_in = 1'b0;
        event_in    = 1'b1;
        ts_ready    = 1'b0;

        // 1. reset, event held high across release
        step();
        step();
        check("rst_valid", {31'b0, ts_valid}, 32'h0);
        check("rst_full", {31'b0, fifo_full}, 32'h0);
        check("rst_drop", {24'b0, drop_cnt}, 32'h0);
        rst = 1'b0;
        step();
        step();
        check("held_evt_no_capture", {31'b0, ts_valid}, 32'h0);

        // 2. single capture and pop
        event_in = 1'b0;
        step();
        count_in = 4'h5;
        event_in = 1'b1;
        step();
        check("t2_valid", {31'b0, ts_valid}, 32'h1);
        check("t2_data", {24'b0, ts_data}, {24'b0, stamp(4'h0, 4'h5)});
        event_in = 1'b0;
        ts_ready = 1'b1;
        step();
        check("t2_popped", {31'b0, ts_valid}, 32'h0);
        ts_ready = 1'b0;

        // 3. overflow rise coincident with event, overflow held 3 cycles
        overflow_in = 1'b1;
        count_in    = 4'h0;
        event_in    = 1'b1;
        step();
        check("t3_data", {24'b0, ts_data}, {24'b0, stamp(4'h1, 4'h0)});
        event_in = 1'b0;
        ts_ready = 1'b1;
        step();
        check("t3_popped", {31'b0, ts_valid}, 32'h0);
        ts_ready = 1'b0;
        step();
        overflow_in = 1'b0;
        step();
        count_in = 4'h2;
        event_in = 1'b1;
        step();
        check("t3_epoch_once", {24'b0, ts_data}, {24'b0, stamp(4'h1, 4'h2)});
        event_in = 1'b0;
        ts_ready = 1'b1;
        step();
        ts_ready = 1'b0;
        check("t3_drained", {31'b0, ts_valid}, 32'h0);

        // restart epoch at 0 for the fill tests
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();

        // 4. fill, overflow the FIFO, drain in order
        pulse_event(4'h1);
        pulse_event(4'h3);
        pulse_event(4'h5);
        check("t4_not_full_3", {31'b0, fifo_full}, 32'h0);
        pulse_event(4'h7);
        check("t4_full_4", {31'b0, fifo_full}, 32'h1);
        check("t4_drop0", {24'b0, drop_cnt}, 32'h0);
        pulse_event(4'h9);
        check("t4_drop1", {24'b0, drop_cnt}, 32'h1);
        check("t4_head_stable", {24'b0, ts_data}, {24'b0, stamp(4'h0, 4'h1)});
        ts_ready = 1'b1;
        check("t4_drain0", {24'b0, ts_data}, {24'b0, stamp(4'h0, 4'h1)});
        step();
        check("t4_drain1", {24'b0, ts_data}, {24'b0, stamp(4'h0, 4'h3)});
        step();
        check("t4_drain2", {24'b0, ts_data}, {24'b0, stamp(4'h0, 4'h5)});
        step();
        check("t4_drain3", {24'b0, ts_data}, {24'b0, stamp(4'h0, 4'h7)});
        step();
        check("t4_empty", {31'b0, ts_valid}, 32'h0);
        ts_ready = 1'b0;

        // 5. full FIFO with simultaneous pop and push
        pulse_event(4'h2);
        pulse_event(4'h4);
        pulse_event(4'h6);
        pulse_event(4'h8);
        check("t5_full", {31'b0, fifo_full}, 32'h1);
        count_in = 4'hA;
        event_in = 1'b1;
        ts_ready = 1'b1;
        step();
        event_in = 1'b0;
        ts_ready = 1'b0;
        check("t5_still_full", {31'b0, fifo_full}, 32'h1);
        check("t5_drop_same", {24'b0, drop_cnt}, 32'h1);
        check("t5_head_adv", {24'b0, ts_data}, {24'b0, stamp(4'h0, 4'h4)});
        ts_ready = 1'b1;
        step();
        check("t5_d1", {24'b0, ts_data}, {24'b0, stamp(4'h0, 4'h6)});
        step();
        check("t5_d2", {24'b0, ts_data}, {24'b0, stamp(4'h0, 4'h8)});
        step();
        check("t5_d3", {24'b0, ts_data}, {24'b0, stamp(4'h0, 4'hA)});
        step();
        check("t5_empty", {31'b0, ts_valid}, 32'h0);
        ts_ready = 1'b0;

        // 6. bump epoch, queue 2 entries, reset flushes and restarts epoch
        overflow_in = 1'b1;
        step();
        overflow_in = 1'b0;
        step();
        pulse_event(4'h4);
        pulse_event(4'h6);
        check("t6_queued_head", {24'b0, ts_data}, {24'b0, stamp(4'h1, 4'h4)});
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_flush_valid", {31'b0, ts_valid}, 32'h0);
        check("t6_flush_drop", {24'b0, drop_cnt}, 32'h0);
        step();
        pulse_event(4'h3);
        check("t6_epoch_restart", {24'b0, ts_data}, {24'b0, stamp(4'h0, 4'h3)});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
